ln_requant: RTL

LN_REQUANT -- requirements
Module: ln_requant

---
 rtl/ln_pkg.sv | 16 +
 rtl/sync_fifo_fwft.sv | 51 +++++
 rtl/ln_requant.sv | 131 +++++++++++++
 3 files changed

// File: rtl/ln_pkg.sv
// Shared defaults and saturation helpers for the layer-norm requantizer.
package ln_pkg;
   localparam int unsigned D_W_DEF     = 8;
   localparam int unsigned D_W_ACC_DEF = 32;
   localparam int unsigned N_DEF       = 768;
   localparam int unsigned M_W_DEF     = 16;

   // Signed saturation limits for a w-bit result.
   function automatic longint sat_max(input int unsigned w);
      return (64'sd1 <<< (w - 1)) - 64'sd1;
   endfunction

   function automatic longint sat_min(input int unsigned w);
      return -(64'sd1 <<< (w - 1));
   endfunction
endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO: o_data shows the head entry whenever the FIFO is not empty.
module sync_fifo_fwft #(
   parameter  int unsigned WIDTH = 8,
   parameter  int unsigned DEPTH = 16,
   localparam int unsigned AW    = $clog2(DEPTH),
   localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_empty,
   output logic             o_full,
   output logic [CW-1:0]    o_count,
   output logic             o_drop
);
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_wr;
   logic             w_rd;

   assign o_empty = (r_count == '0);
   assign o_full  = (r_count == CW'(DEPTH));
   assign w_rd    = i_pop & ~o_empty;
   // A full FIFO still takes a write when the head leaves in the same cycle.
   assign w_wr    = i_push & (~o_full | w_rd);
   assign o_drop  = i_push & ~w_wr;
   assign o_count = r_count;
   assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wr_ptr] <= i_data;
   end

   // Pointers wrap DEPTH-1 -> 0 naturally since DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count <= r_count + CW'(w_wr) - CW'(w_rd);
      end
   end
endmodule

// File: rtl/ln_requant.sv
// Requantizes layer-norm results to D_W bits (multiply, rounding shift, zero point, saturate)
// and buffers them in an output FIFO that throttles the upstream stage via ln_enable.
module ln_requant
   import ln_pkg::*;
#(
   parameter int unsigned D_W     = D_W_DEF,
   parameter int unsigned D_W_ACC = D_W_ACC_DEF,
   parameter int unsigned N       = N_DEF,
   parameter int unsigned M_W     = M_W_DEF,
   parameter int unsigned DEPTH   = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   input  logic signed [D_W_ACC-1:0] qin,
   output logic                      ln_enable,
   input  logic [M_W-1:0]            mult,
   input  logic [4:0]                shift,
   input  logic signed [D_W-1:0]     zp,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic signed [D_W-1:0]     out_data,
   output logic                      out_last,
   output logic                      ovf_err
);
   localparam int unsigned P_W = D_W_ACC + M_W + 1;
   localparam int unsigned S_W = P_W + 1;
   localparam int unsigned CW  = $clog2(DEPTH + 1);
   localparam int unsigned OW  = CW + 2;
   localparam int unsigned IW  = (N > 1) ? $clog2(N) : 1;
   localparam logic signed [S_W-1:0] SAT_HI = S_W'(sat_max(D_W));
   localparam logic signed [S_W-1:0] SAT_LO = S_W'(sat_min(D_W));

   logic                  r_en;
   logic                  r_v1, r_v2, r_v3;
   logic signed [P_W-1:0] r_p, r_r;
   logic signed [D_W-1:0] r_s;
   logic [IW-1:0]         r_idx;
   logic                  r_ovf;

   logic                  w_accept;
   logic signed [P_W-1:0] w_qx, w_mx, w_half, w_sum, w_shr;
   logic signed [S_W-1:0] w_s;
   logic signed [D_W-1:0] w_sat;
   logic [D_W-1:0]        w_fifo_data;
   logic                  w_empty, w_full, w_drop, w_pop;
   logic [CW-1:0]         w_count;
   logic [OW-1:0]         w_occ_nxt;

   assign w_accept = in_valid & r_en;
   assign w_qx     = P_W'(qin);
   assign w_mx     = P_W'($signed({1'b0, mult}));

   always_comb begin
      w_half = '0;
      if (shift != 5'd0) w_half = P_W'(1) << (shift - 5'd1);
   end

   assign w_sum = r_p + w_half;
   assign w_shr = w_sum >>> shift;
   assign w_s   = S_W'(r_r) + S_W'(zp);

   always_comb begin
      if (w_s > SAT_HI)      w_sat = SAT_HI[D_W-1:0];
      else if (w_s < SAT_LO) w_sat = SAT_LO[D_W-1:0];
      else                   w_sat = w_s[D_W-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v1 <= 1'b0;
         r_v2 <= 1'b0;
         r_v3 <= 1'b0;
         r_p  <= '0;
         r_r  <= '0;
         r_s  <= '0;
      end else begin
         r_v1 <= w_accept;
         r_v2 <= r_v1;
         r_v3 <= r_v2;
         r_p  <= w_qx * w_mx;
         r_r  <= w_shr;
         r_s  <= w_sat;
      end
   end

   sync_fifo_fwft #(
      .WIDTH (D_W + 0),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (r_v3),
      .i_data  (r_s),
      .i_pop   (w_pop),
      .o_data  (w_fifo_data),
      .o_empty (w_empty),
      .o_full  (w_full),
      .o_count (w_count),
      .o_drop  (w_drop)
   );

   assign out_valid = ~w_empty;
   assign out_data  = w_fifo_data;
   assign w_pop     = out_valid & out_ready;
   assign out_last  = out_valid & (r_idx == IW'(N - 1));
   assign ln_enable = r_en;
   assign ovf_err   = r_ovf;

   // Everything that will be held after this edge: FIFO entries plus in-flight stages.
   assign w_occ_nxt = OW'(w_count) + OW'(r_v3 & ~w_drop) - OW'(w_pop)
                    + OW'(w_accept) + OW'(r_v1) + OW'(r_v2);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_en  <= 1'b0;
         r_idx <= '0;
         r_ovf <= 1'b0;
      end else begin
         r_en  <= (w_occ_nxt <= OW'(DEPTH - 4));
         r_ovf <= r_ovf | w_drop;
         if (w_pop) begin
            if (r_idx == IW'(N - 1)) r_idx <= '0;
            else                     r_idx <= r_idx + IW'(1);
         end
      end
   end

   logic w_unused;
   assign w_unused = w_full;
endmodule
